reg_file: RTL and testbench

Architectural register file for the MIPS single-cycle datapath: 32 general-purpose registers of 32 bits, two combinational read ports and one synchronous write port. Sits directly downstream of the 5-bit destination-register mux (rt/rd select). That mux's output drives `write_reg`. The read ports feed the ALU operand path and the store-data path. Register `$0` is hardwired to zero.

---
 rtl/reg_file.sv | 95 +++++++++
 tb/tb_reg_file.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// MIPS architectural register file: 32 x DATA_WIDTH, two combinational read ports, one write port, $0 hardwired to zero.
// Optional macro REGFILE_BYPASS_EN enables write-through forwarding of write_data onto the read ports.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] read_reg1,
  input  logic [ADDR_WIDTH-1:0] read_reg2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Entry 0 has no storage; every read mux below falls back to zero for it.
  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [DATA_WIDTH-1:0] regs_d [1:DEPTH-1];
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] stored1_s;
  logic [DATA_WIDTH-1:0] stored2_s;
  logic [DATA_WIDTH-1:0] stored_dbg_s;

  assign wr_en_s = RegWrite && (write_reg != {ADDR_WIDTH{1'b0}});

  // Next-state: only the addressed non-zero entry takes write_data.
  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (wr_en_s && (write_reg == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // State register; synchronous reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read muxes over the stored entries.
  always_comb begin
    stored1_s    = {DATA_WIDTH{1'b0}};
    stored2_s    = {DATA_WIDTH{1'b0}};
    stored_dbg_s = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < DEPTH; i++) begin
      stored1_s    = (read_reg1 == ADDR_WIDTH'(i)) ? regs_q[i] : stored1_s;
      stored2_s    = (read_reg2 == ADDR_WIDTH'(i)) ? regs_q[i] : stored2_s;
      stored_dbg_s = (dbg_addr  == ADDR_WIDTH'(i)) ? regs_q[i] : stored_dbg_s;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic byp1_s;
  logic byp2_s;

  assign byp1_s = wr_en_s && !reset && (write_reg == read_reg1);
  assign byp2_s = wr_en_s && !reset && (write_reg == read_reg2);

  // Forward in-flight write data to a matching read port.
  always_comb begin
    if (byp1_s) begin
      read_data1 = write_data;
    end else begin
      read_data1 = stored1_s;
    end
    if (byp2_s) begin
      read_data2 = write_data;
    end else begin
      read_data2 = stored2_s;
    end
  end
`else
  assign read_data1 = stored1_s;
  assign read_data2 = stored2_s;
`endif

  // The debug port always shows committed contents.
  assign dbg_data = stored_dbg_s;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: spec-level reference model, expected values queued then compared after settling.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int          checks_cnt;
  int          errors_cnt;
  logic [31:0] model [32];
  string       tag_q [$];
  logic [31:0] exp_q [$];

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .read_reg1 (read_reg1),
    .read_reg2 (read_reg2),
    .write_reg (write_reg),
    .write_data(write_data),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected value of a read port at address a under the current inputs.
  function automatic logic [31:0] port_exp(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && !reset && write_reg != 5'd0 && write_reg == a) return write_data;
`endif
    if (a == 5'd0) return 32'd0;
    return model[a];
  endfunction

  function automatic logic [31:0] dbg_exp(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    return model[a];
  endfunction

  // Drive read addresses, queue expectations, let it settle, then pop and compare.
  task automatic probe(input string tag, input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
    read_reg1 = a1;
    read_reg2 = a2;
    dbg_addr  = ad;
    tag_q.push_back({tag, "_rd1"}); exp_q.push_back(port_exp(a1));
    tag_q.push_back({tag, "_rd2"}); exp_q.push_back(port_exp(a2));
    tag_q.push_back({tag, "_dbg"}); exp_q.push_back(dbg_exp(ad));
    #1;
    check_eq(tag_q.pop_front(), read_data1, exp_q.pop_front());
    check_eq(tag_q.pop_front(), read_data2, exp_q.pop_front());
    check_eq(tag_q.pop_front(), dbg_data,   exp_q.pop_front());
  endtask

  // Commit the current inputs to the model and advance one rising edge.
  task automatic do_edge();
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (RegWrite && write_reg != 5'd0) begin
      model[write_reg] = write_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite = 1'b1; write_reg = a; write_data = d;
    do_edge();
    RegWrite = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    reset = 1'b1; RegWrite = 1'b0; write_reg = 5'd0; write_data = 32'd0;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_addr = 5'd0;
    do_edge();
    reset = 1'b0;
    probe("rst_init", 5'd5, 5'd31, 5'd0);
    probe("rst_init2", 5'd0, 5'd1, 5'd31);

    // Reset clear of a written entry
    wr(5'd5, 32'hDEADBEEF);
    probe("wr5", 5'd5, 5'd5, 5'd5);
    reset = 1'b1;
    do_edge();
    reset = 1'b0;
    probe("rst_clear", 5'd5, 5'd31, 5'd5);

    // Basic write/read with same-cycle look
    RegWrite = 1'b1; write_reg = 5'd8; write_data = 32'h12345678;
    probe("basic_pre", 5'd8, 5'd9, 5'd8);
    do_edge();
    RegWrite = 1'b0;
    probe("basic", 5'd8, 5'd9, 5'd8);

    // $0 protection
    RegWrite = 1'b1; write_reg = 5'd0; write_data = 32'hFFFFFFFF;
    probe("zero_pre", 5'd0, 5'd0, 5'd0);
    do_edge();
    RegWrite = 1'b0;
    probe("zero", 5'd0, 5'd8, 5'd0);

    // Reset vs write collision
    wr(5'd3, 32'h00000033);
    reset = 1'b1; RegWrite = 1'b1; write_reg = 5'd3; write_data = 32'hAAAA5555;
    probe("coll_pre", 5'd3, 5'd3, 5'd3);
    do_edge();
    reset = 1'b0; RegWrite = 1'b0;
    probe("coll", 5'd3, 5'd8, 5'd3);

    // Same-cycle read-after-write
    wr(5'd4, 32'h00000011);
    RegWrite = 1'b1; write_reg = 5'd4; write_data = 32'h00000022;
    probe("raw_pre", 5'd4, 5'd4, 5'd4);
    do_edge();
    RegWrite = 1'b0;
    probe("raw_post", 5'd4, 5'd4, 5'd4);

    // Write-after-write on consecutive edges
    wr(5'd7, 32'h00000001);
    wr(5'd7, 32'h00000002);
    probe("waw", 5'd7, 5'd4, 5'd7);

    // RegWrite gating and dual ports
    wr(5'd10, 32'h0000000A);
    wr(5'd20, 32'h0000000B);
    RegWrite = 1'b0; write_reg = 5'd10; write_data = 32'h0000000C;
    probe("gate_pre", 5'd10, 5'd20, 5'd10);
    do_edge();
    probe("gate", 5'd10, 5'd20, 5'd20);

    // Multi-cycle reset with writes attempted, then resume
    for (int c = 0; c < 3; c++) begin
      reset = 1'b1; RegWrite = 1'b1; write_reg = 5'(c + 11); write_data = 32'hC0DE0000 + 32'(c);
      probe("hold_pre", 5'(c + 11), 5'd10, 5'd20);
      do_edge();
      probe("hold", 5'(c + 11), 5'd10, 5'd20);
    end
    reset = 1'b0; RegWrite = 1'b1; write_reg = 5'd12; write_data = 32'h00000005;
    do_edge();
    RegWrite = 1'b0;
    probe("resume", 5'd12, 5'd11, 5'd12);

    // Randomised traffic against the model
    for (int n = 0; n < 80; n++) begin
      logic [4:0] a1;
      logic [4:0] a2;
      reset      = ($urandom_range(0, 19) == 0);
      RegWrite   = 1'($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      a1 = ($urandom_range(0, 1) == 0) ? write_reg : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) == 0) ? write_reg : 5'($urandom_range(0, 31));
      probe("rnd_pre", a1, a2, write_reg);
      do_edge();
      probe("rnd_post", a2, a1, 5'($urandom_range(0, 31)));
    end

    if (tag_q.size() != 0) begin
      check_eq("sb_drain", 32'(tag_q.size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
